// File: rtl/multi_cycle_core.sv
// Multi-cycle RV32I-subset core: one shared req/ack memory port for fetch and data,
// a state-machine sequencer, and a sticky halt on illegal or misaligned operations.
module multi_cycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              halt,
  output logic [31:0]       pc_dbg
);
  localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef enum logic [3:0] {
    S_BOOT, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BEQ, S_JAL, S_HALT
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_pc, r_old_pc, r_ir, r_alu_out, r_mdr;
  logic [31:0] r_regs [NREGS];

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [RIDX_W-1:0] w_rd, w_rs1, w_rs2;
  logic [31:0]       w_rs1_val, w_rs2_val;
  logic [31:0]       w_imm_i, w_imm_s, w_imm_b, w_imm_j;
  logic [31:0]       w_alu_b, w_alu_res, w_addr_sum, w_br_target, w_jal_target;
  logic              w_alu_ok, w_taken, w_rf_we;
  logic [31:0]       w_rf_wdata;

  assign w_opcode  = r_ir[6:0];
  assign w_funct3  = r_ir[14:12];
  // Index bits above log2(NREGS) are dropped, so x17 aliases x1 on RV32E.
  assign w_rd      = r_ir[7 +: RIDX_W];
  assign w_rs1     = r_ir[15 +: RIDX_W];
  assign w_rs2     = r_ir[20 +: RIDX_W];
  assign w_rs1_val = r_regs[w_rs1];
  assign w_rs2_val = r_regs[w_rs2];

  assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

  assign w_addr_sum   = w_rs1_val + ((w_opcode == OP_STORE) ? w_imm_s : w_imm_i);
  assign w_br_target  = r_old_pc + w_imm_b;
  assign w_jal_target = r_old_pc + w_imm_j;
  assign w_taken      = (w_rs1_val == w_rs2_val);
  assign w_alu_b      = (r_state == S_EXEC_R) ? w_rs2_val : w_imm_i;

  always_comb begin
    w_alu_ok  = 1'b1;
    w_alu_res = '0;
    case (w_funct3)
      3'b000:  w_alu_res = (w_opcode == OP_REG && r_ir[30]) ? (w_rs1_val - w_alu_b)
                                                             : (w_rs1_val + w_alu_b);
      3'b111:  w_alu_res = w_rs1_val & w_alu_b;
      3'b110:  w_alu_res = w_rs1_val | w_alu_b;
      3'b010:  w_alu_res = {31'b0, $signed(w_rs1_val) < $signed(w_alu_b)};
      default: w_alu_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_BOOT;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    halt      = 1'b0;
    case (r_state)
      S_BOOT:  w_next = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = r_pc[ADDR_W-1:0];
        if (mem_ack) w_next = S_DECODE;
      end
      S_DECODE: begin
        case (w_opcode)
          OP_LOAD, OP_STORE: w_next = (w_funct3 == 3'b010) ? S_MEMADR : S_HALT;
          OP_REG:            w_next = w_alu_ok ? S_EXEC_R : S_HALT;
          OP_IMM:            w_next = w_alu_ok ? S_EXEC_I : S_HALT;
          OP_BRANCH:         w_next = (w_funct3 == 3'b000) ? S_BEQ : S_HALT;
          OP_JAL:            w_next = S_JAL;
          default:           w_next = S_HALT;
        endcase
      end
      S_MEMADR: begin
        if (w_addr_sum[1:0] != 2'b00)  w_next = S_HALT;
        else if (w_opcode == OP_LOAD)  w_next = S_MEMREAD;
        else                           w_next = S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req  = 1'b1;
        mem_addr = r_alu_out[ADDR_W-1:0];
        if (mem_ack) w_next = S_MEMWB;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_alu_out[ADDR_W-1:0];
        mem_wdata = w_rs2_val;
        if (mem_ack) w_next = S_FETCH;
      end
      S_MEMWB, S_ALUWB:   w_next = S_FETCH;
      S_EXEC_R, S_EXEC_I: w_next = S_ALUWB;
      S_BEQ:   w_next = (w_taken && w_br_target[1:0] != 2'b00) ? S_HALT : S_FETCH;
      S_JAL:   w_next = (w_jal_target[1:0] != 2'b00) ? S_HALT : S_ALUWB;
      S_HALT:  halt = 1'b1;
      default: w_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= RESET_PC;
      r_old_pc  <= '0;
      r_ir      <= '0;
      r_alu_out <= '0;
      r_mdr     <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (mem_ack) begin
          r_ir     <= mem_rdata;
          r_old_pc <= r_pc;
          r_pc     <= r_pc + 32'd4;
        end
        S_MEMADR:           r_alu_out <= w_addr_sum;
        S_MEMREAD:          if (mem_ack) r_mdr <= mem_rdata;
        S_EXEC_R, S_EXEC_I: r_alu_out <= w_alu_res;
        S_BEQ:   if (w_taken && w_br_target[1:0] == 2'b00) r_pc <= w_br_target;
        S_JAL: begin
          if (w_jal_target[1:0] == 2'b00) r_pc <= w_jal_target;
          r_alu_out <= r_old_pc + 32'd4;
        end
        default: ;
      endcase
    end
  end

  assign w_rf_we    = (r_state == S_MEMWB || r_state == S_ALUWB) && (w_rd != '0);
  assign w_rf_wdata = (r_state == S_MEMWB) ? r_mdr : r_alu_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_rf_we) begin
      r_regs[w_rd] <= w_rf_wdata;
    end
  end

  assign pc_dbg = r_pc;
endmodule

// File: tb/tb_multi_cycle_core.sv
// Directed programs for multi_cycle_core; expected memory transactions are queued
// by the stimulus and checked by an independent monitor as the DUT completes them.
module tb_multi_cycle_core;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we, mem_ack, halt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gap;
  } txn_t;

  txn_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          wait_n = 0;
  bit          spur = 1'b0;
  logic [31:0] mem [0:255];

  multi_cycle_core #(.RESET_PC(32'h0), .NREGS(16), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .halt(halt), .pc_dbg(pc_dbg)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input bit we, input logic [31:0] addr, input logic [31:0] wd, input int gap);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wd; t.gap = gap;
    exp_q.push_back(t);
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_lw(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [4:0] rd);
    return {imm, rs1, 3'b010, rd, 7'h03};
  endfunction
  function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_beq(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_jal(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  // Memory responder: wait_n stall cycles per request, optional spurious ack when idle.
  initial begin
    int cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_ack = 1'b0; cnt = 0;
      end else if (mem_req) begin
        if (cnt >= wait_n) begin
          mem_ack = 1'b1; cnt = 0;
          if (mem_we) begin
            mem[mem_addr[9:2]] = mem_wdata; mem_rdata = '0;
          end else begin
            mem_rdata = mem[mem_addr[9:2]];
          end
        end else begin
          mem_ack = 1'b0; cnt++;
        end
      end else begin
        mem_ack = spur; mem_rdata = 32'hDEAD_BEEF; cnt = 0;
      end
    end
  end

  // Monitor: stability while stalled, and each completed transaction against the queue.
  initial begin
    bit          in_req = 1'b0;
    bit          h_we = 1'b0;
    logic [31:0] h_addr = '0;
    logic [31:0] h_wd = '0;
    int          last = 0;
    txn_t        e;
    forever begin
      @(negedge clk); #1;
      if (mem_req) begin
        if (in_req) begin
          check32("hold_addr", mem_addr, h_addr);
          check32("hold_we", {31'b0, mem_we}, {31'b0, h_we});
          check32("hold_wdata", mem_wdata, h_wd);
        end else begin
          h_addr = mem_addr; h_we = mem_we; h_wd = mem_wdata;
        end
        if (mem_ack) begin
          in_req = 1'b0;
          $display("txn: we=%b addr=%h wdata=%h cycle=%0d", mem_we, mem_addr, mem_wdata, cyc);
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_txn: got addr %h we %b, expected no transaction",
                     mem_addr, mem_we);
          end else begin
            e = exp_q.pop_front();
            check32("txn_we", {31'b0, mem_we}, {31'b0, e.we});
            check32("txn_addr", mem_addr, e.addr);
            if (e.we) check32("txn_wdata", mem_wdata, e.wdata);
            if (e.gap >= 0) check32("txn_gap", cyc - last, e.gap);
          end
          last = cyc;
        end else begin
          in_req = 1'b1;
        end
      end else begin
        in_req = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); #3;
    rst = 1'b0;
    #1;
    check32("rst_req", {31'b0, mem_req}, 32'd0);
    check32("rst_halt", {31'b0, halt}, 32'd0);
    check32("rst_pc", pc_dbg, 32'h0);
    check32("rst_addr", mem_addr, 32'h0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i++) mem[i] = 32'hFFFF_FFFF;
  endtask

  task automatic start();
    @(negedge clk);
    rst = 1'b1;
    #2;
    check32("boot_req", {31'b0, mem_req}, 32'd0);
  endtask

  task automatic finish_prog(input logic [31:0] pc_exp);
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk); #2;
      if (halt) done = 1'b1;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL halt_timeout: got halt=0 after 3000 cycles, expected halt=1");
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      check32("halt_sticky", {31'b0, halt}, 32'd1);
      check32("halt_no_req", {31'b0, mem_req}, 32'd0);
    end
    check32("pending_txns", exp_q.size(), 32'd0);
    check32("final_pc", pc_dbg, pc_exp);
    exp_q.delete();
  endtask

  initial begin
    // Zero-wait addi, then store x1 to observe it
    wait_n = 0; spur = 1'b0;
    do_reset();
    mem[0] = enc_i(12'h005, 5'd0, 3'b000, 5'd1);
    mem[1] = enc_sw(12'h080, 5'd1, 5'd0);
    push(0, 32'h00, 0, -1); push(0, 32'h04, 0, 4);
    push(1, 32'h80, 32'd5, 3); push(0, 32'h08, 0, 1);
    start();
    @(negedge clk); #2;
    check32("first_fetch_req", {31'b0, mem_req}, 32'd1);
    check32("first_fetch_addr", mem_addr, 32'h0);
    @(negedge clk); #2;
    check32("pc_after_fetch", pc_dbg, 32'h4);
    finish_prog(32'h0C);

    // Store/load round trip with 3 wait states and spurious idle acks
    wait_n = 3; spur = 1'b1;
    do_reset();
    mem[0] = enc_i(12'h007, 5'd0, 3'b000, 5'd1);
    mem[1] = enc_sw(12'h040, 5'd1, 5'd0);
    mem[2] = enc_lw(12'h040, 5'd0, 5'd2);
    mem[3] = enc_sw(12'h044, 5'd2, 5'd0);
    push(0, 32'h00, 0, -1); push(0, 32'h04, 0, 7);
    push(1, 32'h40, 32'd7, 6); push(0, 32'h08, 0, 4);
    push(0, 32'h40, 0, 6); push(0, 32'h0C, 0, 5);
    push(1, 32'h44, 32'd7, 6); push(0, 32'h10, 0, 4);
    start();
    finish_prog(32'h14);
    spur = 1'b0;

    // Branches and jumps
    wait_n = 0;
    do_reset();
    mem[0]  = enc_i(12'h001, 5'd0, 3'b000, 5'd1);
    mem[1]  = enc_jal(21'h00000C, 5'd0);
    mem[3]  = enc_jal(21'h00000C, 5'd0);
    mem[4]  = enc_beq(13'h1FFC, 5'd0, 5'd0);
    mem[6]  = enc_beq(13'h0008, 5'd0, 5'd1);
    mem[7]  = enc_sw(12'h084, 5'd0, 5'd0);
    mem[8]  = enc_jal(21'h000008, 5'd5);
    mem[10] = enc_sw(12'h088, 5'd5, 5'd0);
    push(0, 32'h00, 0, -1); push(0, 32'h04, 0, 4); push(0, 32'h10, 0, 4);
    push(0, 32'h0C, 0, 3);  push(0, 32'h18, 0, 4); push(0, 32'h1C, 0, 3);
    push(1, 32'h84, 32'h0, 3); push(0, 32'h20, 0, 1); push(0, 32'h28, 0, 4);
    push(1, 32'h88, 32'h24, 3); push(0, 32'h2C, 0, 1);
    start();
    finish_prog(32'h30);

    // Misaligned load address traps
    wait_n = 1;
    do_reset();
    mem[0] = enc_i(12'h041, 5'd0, 3'b000, 5'd1);
    mem[1] = enc_lw(12'h000, 5'd1, 5'd2);
    push(0, 32'h00, 0, -1); push(0, 32'h04, 0, 5);
    start();
    finish_prog(32'h08);

    // Misaligned jal / taken-beq targets trap without moving the PC
    wait_n = 0;
    do_reset();
    mem[0] = enc_jal(21'h000006, 5'd1);
    push(0, 32'h00, 0, -1);
    start();
    finish_prog(32'h04);
    do_reset();
    mem[0] = enc_beq(13'h0002, 5'd0, 5'd0);
    push(0, 32'h00, 0, -1);
    start();
    finish_prog(32'h04);

    // Reset asserted in the middle of a stalled fetch, then a clean restart
    wait_n = 5;
    do_reset();
    mem[0] = enc_i(12'h009, 5'd0, 3'b000, 5'd1);
    mem[1] = enc_sw(12'h08C, 5'd1, 5'd0);
    start();
    repeat (3) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check32("abort_req", {31'b0, mem_req}, 32'd0);
    check32("abort_pc", pc_dbg, 32'h0);
    repeat (2) @(negedge clk);
    push(0, 32'h00, 0, -1); push(0, 32'h04, 0, 9);
    push(1, 32'h8C, 32'd9, 8); push(0, 32'h08, 0, 6);
    start();
    finish_prog(32'h0C);

    // RV32E aliasing (x17 -> x1, x20 -> x4) and ALU wrap / signed compare / sub
    wait_n = 0;
    do_reset();
    mem[0] = enc_i(12'hFFF, 5'd0, 3'b000, 5'd17);
    mem[1] = enc_i(12'h001, 5'd0, 3'b000, 5'd2);
    mem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    mem[3] = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd4);
    mem[4] = enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd6);
    mem[5] = enc_sw(12'h090, 5'd3, 5'd0);
    mem[6] = enc_sw(12'h094, 5'd20, 5'd0);
    mem[7] = enc_sw(12'h098, 5'd6, 5'd0);
    push(0, 32'h00, 0, -1); push(0, 32'h04, 0, 4); push(0, 32'h08, 0, 4);
    push(0, 32'h0C, 0, 4);  push(0, 32'h10, 0, 4); push(0, 32'h14, 0, 4);
    push(1, 32'h90, 32'h0, 3); push(0, 32'h18, 0, 1);
    push(1, 32'h94, 32'h1, 3); push(0, 32'h1C, 0, 1);
    push(1, 32'h98, 32'h2, 3); push(0, 32'h20, 0, 1);
    start();
    finish_prog(32'h24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
